frame_slot_manager: RTL and testbench
=====================================

# frame_slot_manager

Owns allocation of the DDR frame-buffer slots in the 133 MHz domain. The camera writer is handed a free slot for each incoming frame. Two readers (VGA row buffer and UART dump) lock the newest completed frame for as long as they need it. A slot is never overwritten while a reader holds it, so no reader ever sees a frame that is being written over.

## Interface
Parameters:
- NUM_SLOTS, 4, number of frame slots; must be ≥ 4 so allocation can never fail in legal use.
- SLOT_BITS, 2, width of a slot index; equals clog2(NUM_SLOTS).
- SLOT_STRIDE, 25'h0010000, DDR word-address distance between slot bases.

Ports:
- clk_133M  in  1  sole clock.
- rst_n_133M  in  1  reset, synchronous and active-low.
- wr_start  in  1  pulse: the camera begins a frame.
- wr_done  in  1  pulse: the camera has finished writing the current frame.
- wr_grant  out  1  pulse: wr_slot and wr_base are valid for the new frame.
- wr_slot  out  SLOT_BITS  slot being written.
- wr_base  out  25  equals wr_slot*SLOT_STRIDE.
- wr_drop  out  1  pulse: wr_start was refused because no slot is allocatable.
- rd_acquire  in  2  per-reader pulse (bit0 = VGA, bit1 = UART).
- rd_release  in  2  per-reader pulse.
- rd_grant  out  2  per-reader pulse: the acquire succeeded.
- rd_slot0, rd_slot1  out  SLOT_BITS  slot held by each reader.
- rd_base0, rd_base1  out  25  base address of the held slot.
- rd_held  out  2  level: the reader currently holds a slot.
- newest_valid  out  1  at least one frame has completed.
- newest_slot  out  SLOT_BITS  most recently completed slot.
- frame_count  out  16  completed frames; wraps at 16'hFFFF→0.
- drop_count  out  8  refused wr_start events; saturates at 8'hFF.

## Operation
- Slot state is FREE, WRITING or READY. Each reader also has a held bit and a held index.
- Reset: all slots FREE; every output 0; writer IDLE.
- Writer FSM has two states, IDLE and ACTIVE.
  - wr_start in either state: if ACTIVE, the current slot returns to FREE (frame aborted). Then allocate.
  - Allocation picks the lowest-index slot that is not WRITING, not held by any reader, and not newest_slot while newest_valid is set.
  - If a slot is found: mark it WRITING, pulse wr_grant, go to ACTIVE.
  - If none is found: pulse wr_drop, increment drop_count, go to IDLE.
  - wr_done in ACTIVE: slot becomes READY; newest_slot ← slot; newest_valid ← 1; frame_count +1; go to IDLE. The previous newest slot becomes FREE unless a reader holds it.
  - wr_done in IDLE is ignored.
- Readers:
  - rd_acquire[i] while newest_valid=1 and not held: hold newest_slot, pulse rd_grant[i].
  - rd_acquire[i] while already held: re-latch to the current newest_slot (the old slot is released) and pulse rd_grant[i].
  - rd_acquire[i] while newest_valid=0: ignored, no grant.
  - rd_release[i]: clear the held bit. If the slot is READY, is not the newest slot, and is not held by the other reader, it becomes FREE.
  - rd_release[i] while not held is ignored.
- Both readers may hold the same slot at once.
- Simultaneous events: all decisions use state as registered at the start of the cycle.
  - wr_done together with rd_acquire: the reader gets the old newest_slot.
  - rd_acquire and rd_release on the same reader in the same cycle: acquire wins.
- Invariant: with NUM_SLOTS ≥ 4, at most 3 slots are blocked (one newest, two held). wr_drop therefore only occurs when NUM_SLOTS < 4; the logic must still handle that case.

## Timing
- wr_grant / wr_drop, wr_slot and wr_base are registered: they appear 1 cycle after wr_start.
- wr_slot and wr_base remain stable until the next wr_grant.
- rd_grant, rd_slotN, rd_baseN and rd_held update 1 cycle after rd_acquire or rd_release.
- newest_slot, newest_valid and frame_count update 1 cycle after wr_done.
- All pulses are exactly 1 cycle wide. Inputs are single-cycle pulses, already synchronised by the caller.
- Reset asserted mid-frame: on the next clock edge all slots are FREE, holds are cleared and the counters are zero. No grant is issued during reset.

## Test plan
- Reset, then wr_start → wr_grant at +1 with wr_slot=0, wr_base=0. Then wr_done → newest_slot=0, newest_valid=1, frame_count=1.
- Reader locks a frame: complete frame 0; rd_acquire=2'b01 → rd_slot0=0, rd_held=01. Run three more wr_start/wr_done frames → granted slots are 1, 2, 1 in order; slot 0 is never granted while held.
- Both readers hold: both acquire the same newest slot 2, then release bit0 → slot 2 stays unavailable because bit1 still holds it. Release bit1 → slot 2 becomes allocatable once it is no longer newest.
- Abort: wr_start, then wr_start again with no wr_done → first slot freed and second grant is slot 0 again. wr_done alone in IDLE → frame_count unchanged.
- Same-cycle race: wr_done (slot 1) together with rd_acquire[1] while newest=0 → rd_slot1=0, newest_slot=1.
- NUM_SLOTS=2 build: newest 0 plus reader holding... with slot 1 WRITING, a second wr_start aborts slot 1 and regrants it. Then with newest=1 and reader holding 0, wr_start → wr_drop, drop_count=1. Repeat 300 times → drop_count=255.

Source files
------------

// File: rtl/frame_slot_manager_if.sv
// Frame slot manager bus: writer and reader handshakes plus status.
// SLOT_BITS must match the slot index width of the attached manager.
interface frame_slot_manager_if #(
  parameter int SLOT_BITS = 2
);
  logic                 wr_start;
  logic                 wr_done;
  logic                 wr_grant;
  logic [SLOT_BITS-1:0] wr_slot;
  logic [24:0]          wr_base;
  logic                 wr_drop;
  logic [1:0]           rd_acquire;
  logic [1:0]           rd_release;
  logic [1:0]           rd_grant;
  logic [SLOT_BITS-1:0] rd_slot0;
  logic [SLOT_BITS-1:0] rd_slot1;
  logic [24:0]          rd_base0;
  logic [24:0]          rd_base1;
  logic [1:0]           rd_held;
  logic                 newest_valid;
  logic [SLOT_BITS-1:0] newest_slot;
  logic [15:0]          frame_count;
  logic [7:0]           drop_count;

  modport master (
    output wr_start, wr_done, rd_acquire, rd_release,
    input  wr_grant, wr_slot, wr_base, wr_drop,
    input  rd_grant, rd_slot0, rd_slot1, rd_base0, rd_base1,
    input  rd_held, newest_valid, newest_slot,
    input  frame_count, drop_count
  );

  modport slave (
    input  wr_start, wr_done, rd_acquire, rd_release,
    output wr_grant, wr_slot, wr_base, wr_drop,
    output rd_grant, rd_slot0, rd_slot1, rd_base0, rd_base1,
    output rd_held, newest_valid, newest_slot,
    output frame_count, drop_count
  );
endinterface

// File: rtl/frame_slot_manager.sv
// DDR frame-buffer slot allocator: one camera writer, two readers
// locking the newest completed frame, never overwriting a held slot.
module frame_slot_manager #(
  parameter int          NUM_SLOTS   = 4,
  parameter int          SLOT_BITS   = 2,
  parameter logic [24:0] SLOT_STRIDE = 25'h0010000
) (
  input  logic clk_133M,
  input  logic rst_n_133M,
  frame_slot_manager_if.slave bus
);

  typedef enum logic {IDLE, ACTIVE} wr_state_t;
  typedef enum logic [1:0] {FREE, WRITING, READY} slot_state_t;

  wr_state_t   state, state_n;
  slot_state_t slot_st   [NUM_SLOTS];
  slot_state_t slot_st_n [NUM_SLOTS];

  logic [SLOT_BITS-1:0]      wr_slot_q, wr_slot_n;
  logic [SLOT_BITS-1:0]      newest_q, newest_n;
  logic [1:0][SLOT_BITS-1:0] hslot_q, hslot_n;
  logic [1:0]                held_q, held_n;
  logic [1:0]                rgrant_q, rgrant_n;
  logic                      nv_q, nv_n;
  logic                      grant_q, grant_n;
  logic                      drop_q, drop_n;
  logic [15:0]               fc_q, fc_n;
  logic [7:0]                dc_q, dc_n;
  logic                      alloc_ok;
  logic [SLOT_BITS-1:0]      alloc_slot;

  // The slot being aborted by a restart is reusable in the same cycle.
  always_comb begin
    alloc_ok   = 1'b0;
    alloc_slot = '0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (slot_st[s] == FREE ||
          (state == ACTIVE && wr_slot_q == SLOT_BITS'(s))) begin
        alloc_ok   = 1'b1;
        alloc_slot = SLOT_BITS'(s);
      end
    end
  end

  always_comb begin
    state_n   = state;
    wr_slot_n = wr_slot_q;
    grant_n   = 1'b0;
    drop_n    = 1'b0;
    nv_n      = nv_q;
    newest_n  = newest_q;
    fc_n      = fc_q;
    dc_n      = dc_q;
    if (bus.wr_start) begin
      if (alloc_ok) begin
        state_n   = ACTIVE;
        wr_slot_n = alloc_slot;
        grant_n   = 1'b1;
      end else begin
        state_n = IDLE;
        drop_n  = 1'b1;
        if (dc_q != 8'hFF) dc_n = dc_q + 8'd1;
      end
    end else if (bus.wr_done && state == ACTIVE) begin
      state_n  = IDLE;
      nv_n     = 1'b1;
      newest_n = wr_slot_q;
      fc_n     = fc_q + 16'd1;
    end
  end

  always_comb begin
    held_n   = held_q;
    hslot_n  = hslot_q;
    rgrant_n = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (bus.rd_acquire[i] && nv_q) begin
        held_n[i]   = 1'b1;
        hslot_n[i]  = newest_q;
        rgrant_n[i] = 1'b1;
      end else if (bus.rd_release[i]) begin
        held_n[i] = 1'b0;
      end
    end
  end

  // A slot stays READY only while it is newest or held by a reader.
  always_comb begin
    for (int s = 0; s < NUM_SLOTS; s++) begin
      slot_st_n[s] = FREE;
      if (state_n == ACTIVE && wr_slot_n == SLOT_BITS'(s))
        slot_st_n[s] = WRITING;
      else if ((nv_n && newest_n == SLOT_BITS'(s)) ||
               (held_n[0] && hslot_n[0] == SLOT_BITS'(s)) ||
               (held_n[1] && hslot_n[1] == SLOT_BITS'(s)))
        slot_st_n[s] = READY;
    end
  end

  always_ff @(posedge clk_133M) begin
    if (!rst_n_133M) begin
      state     <= IDLE;
      wr_slot_q <= '0;
      newest_q  <= '0;
      hslot_q   <= '0;
      held_q    <= 2'b00;
      rgrant_q  <= 2'b00;
      nv_q      <= 1'b0;
      grant_q   <= 1'b0;
      drop_q    <= 1'b0;
      fc_q      <= '0;
      dc_q      <= '0;
      for (int s = 0; s < NUM_SLOTS; s++) slot_st[s] <= FREE;
    end else begin
      state     <= state_n;
      wr_slot_q <= wr_slot_n;
      newest_q  <= newest_n;
      hslot_q   <= hslot_n;
      held_q    <= held_n;
      rgrant_q  <= rgrant_n;
      nv_q      <= nv_n;
      grant_q   <= grant_n;
      drop_q    <= drop_n;
      fc_q      <= fc_n;
      dc_q      <= dc_n;
      for (int s = 0; s < NUM_SLOTS; s++) slot_st[s] <= slot_st_n[s];
    end
  end

  assign bus.wr_grant     = grant_q;
  assign bus.wr_drop      = drop_q;
  assign bus.wr_slot      = wr_slot_q;
  assign bus.wr_base      = 25'(wr_slot_q) * SLOT_STRIDE;
  assign bus.rd_grant     = rgrant_q;
  assign bus.rd_held      = held_q;
  assign bus.rd_slot0     = hslot_q[0];
  assign bus.rd_slot1     = hslot_q[1];
  assign bus.rd_base0     = 25'(hslot_q[0]) * SLOT_STRIDE;
  assign bus.rd_base1     = 25'(hslot_q[1]) * SLOT_STRIDE;
  assign bus.newest_valid = nv_q;
  assign bus.newest_slot  = newest_q;
  assign bus.frame_count  = fc_q;
  assign bus.drop_count   = dc_q;

endmodule

// File: tb/tb_frame_slot_manager.sv
// Bench for frame_slot_manager: 4-slot and 2-slot builds against
// a rule-level model, directed scenarios plus random traffic.
module tb_frame_slot_manager;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bit       ws [2];
  bit       wd [2];
  bit [1:0] ra [2];
  bit [1:0] rr [2];

  frame_slot_manager_if #(.SLOT_BITS(2)) b4 ();
  frame_slot_manager_if #(.SLOT_BITS(1)) b2 ();

  assign b4.wr_start   = ws[0];
  assign b4.wr_done    = wd[0];
  assign b4.rd_acquire = ra[0];
  assign b4.rd_release = rr[0];
  assign b2.wr_start   = ws[1];
  assign b2.wr_done    = wd[1];
  assign b2.rd_acquire = ra[1];
  assign b2.rd_release = rr[1];

  frame_slot_manager #(
    .NUM_SLOTS(4), .SLOT_BITS(2), .SLOT_STRIDE(25'h0010000)
  ) dut4 (
    .clk_133M(clk), .rst_n_133M(rst_n), .bus(b4)
  );

  frame_slot_manager #(
    .NUM_SLOTS(2), .SLOT_BITS(1), .SLOT_STRIDE(25'h0010000)
  ) dut2 (
    .clk_133M(clk), .rst_n_133M(rst_n), .bus(b2)
  );

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  // Reference model: per build, slot sets expressed as plain values.
  int       m_ns [2] = '{4, 2};
  bit       m_act [2];
  int       m_wslot [2];
  bit       m_g [2];
  bit       m_d [2];
  bit [1:0] m_rg [2];
  bit       m_nv [2];
  int       m_new [2];
  bit [1:0] m_held [2];
  int       m_hs [2][2];
  int       m_fc [2];
  int       m_dc [2];

  task automatic model_step(int k);
    bit [1:0] h;
    int hs0, hs1, nw, pick;
    bit nv;
    m_g[k] = 0;
    m_d[k] = 0;
    m_rg[k] = 0;
    if (!rst_n) begin
      m_act[k] = 0; m_wslot[k] = 0;
      m_nv[k] = 0; m_new[k] = 0;
      m_held[k] = 0; m_hs[k][0] = 0; m_hs[k][1] = 0;
      m_fc[k] = 0; m_dc[k] = 0;
      return;
    end
    h = m_held[k];
    hs0 = m_hs[k][0];
    hs1 = m_hs[k][1];
    nv = m_nv[k];
    nw = m_new[k];
    if (ws[k]) begin
      // a restart frees the written slot, so only newest/held block
      pick = -1;
      for (int s = 0; s < m_ns[k]; s++)
        if (pick < 0 && !(nv && nw == s) &&
            !(h[0] && hs0 == s) && !(h[1] && hs1 == s))
          pick = s;
      if (pick >= 0) begin
        m_act[k] = 1; m_wslot[k] = pick; m_g[k] = 1;
      end else begin
        m_act[k] = 0; m_d[k] = 1;
        if (m_dc[k] < 255) m_dc[k]++;
      end
    end else if (wd[k] && m_act[k]) begin
      m_act[k] = 0;
      m_nv[k] = 1;
      m_new[k] = m_wslot[k];
      m_fc[k] = (m_fc[k] + 1) % 65536;
    end
    for (int i = 0; i < 2; i++)
      if (ra[k][i] && nv) begin
        m_held[k][i] = 1; m_hs[k][i] = nw; m_rg[k][i] = 1;
      end else if (rr[k][i]) begin
        m_held[k][i] = 0;
      end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic chk(int k, string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL k%0d %s: got %0h expected %0h at %0t",
                  k, nm, act, exp, $time);
  endtask

  task automatic cmp(int k, logic [31:0] wg, logic [31:0] wsl,
                     logic [31:0] wb, logic [31:0] wdr,
                     logic [31:0] rg, logic [31:0] rs0,
                     logic [31:0] rs1, logic [31:0] rb0,
                     logic [31:0] rb1, logic [31:0] rh,
                     logic [31:0] nv, logic [31:0] ns,
                     logic [31:0] fc, logic [31:0] dc);
    chk(k, "wr_grant", wg, 32'(m_g[k]));
    chk(k, "wr_slot", wsl, m_wslot[k]);
    chk(k, "wr_base", wb, m_wslot[k] * 32'h10000);
    chk(k, "wr_drop", wdr, 32'(m_d[k]));
    chk(k, "rd_grant", rg, 32'(m_rg[k]));
    chk(k, "rd_slot0", rs0, m_hs[k][0]);
    chk(k, "rd_slot1", rs1, m_hs[k][1]);
    chk(k, "rd_base0", rb0, m_hs[k][0] * 32'h10000);
    chk(k, "rd_base1", rb1, m_hs[k][1] * 32'h10000);
    chk(k, "rd_held", rh, 32'(m_held[k]));
    chk(k, "newest_valid", nv, 32'(m_nv[k]));
    chk(k, "newest_slot", ns, m_new[k]);
    chk(k, "frame_count", fc, m_fc[k]);
    chk(k, "drop_count", dc, m_dc[k]);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, 32'(b4.wr_grant), 32'(b4.wr_slot), 32'(b4.wr_base),
          32'(b4.wr_drop), 32'(b4.rd_grant), 32'(b4.rd_slot0),
          32'(b4.rd_slot1), 32'(b4.rd_base0), 32'(b4.rd_base1),
          32'(b4.rd_held), 32'(b4.newest_valid), 32'(b4.newest_slot),
          32'(b4.frame_count), 32'(b4.drop_count));
      cmp(1, 32'(b2.wr_grant), 32'(b2.wr_slot), 32'(b2.wr_base),
          32'(b2.wr_drop), 32'(b2.rd_grant), 32'(b2.rd_slot0),
          32'(b2.rd_slot1), 32'(b2.rd_base0), 32'(b2.rd_base1),
          32'(b2.rd_held), 32'(b2.newest_valid), 32'(b2.newest_slot),
          32'(b2.frame_count), 32'(b2.drop_count));
    end
  end

  task automatic step(int k, bit s, bit d, bit [1:0] a, bit [1:0] r);
    ws[k] = s; wd[k] = d; ra[k] = a; rr[k] = r;
    @(negedge clk);
    ws[k] = 0; wd[k] = 0; ra[k] = 0; rr[k] = 0;
  endtask

  int exp_seq [3] = '{1, 2, 1};

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk(0, "rst_grant", 32'(b4.wr_grant), 0);
    chk(0, "rst_valid", 32'(b4.newest_valid), 0);
    chk(0, "rst_fc", 32'(b4.frame_count), 0);
    rst_n = 1'b1;

    step(0, 1, 0, 0, 0);
    chk(0, "first_grant", 32'(b4.wr_grant), 1);
    chk(0, "first_slot", 32'(b4.wr_slot), 0);
    chk(0, "first_base", 32'(b4.wr_base), 0);
    step(0, 0, 1, 0, 0);
    chk(0, "first_newest", 32'(b4.newest_slot), 0);
    chk(0, "first_valid", 32'(b4.newest_valid), 1);
    chk(0, "first_fc", 32'(b4.frame_count), 1);

    step(0, 0, 0, 2'b01, 0);
    chk(0, "lock_slot0", 32'(b4.rd_slot0), 0);
    chk(0, "lock_held", 32'(b4.rd_held), 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 0);
      chk(0, "locked_seq", 32'(b4.wr_slot), exp_seq[i]);
      step(0, 0, 1, 0, 0);
    end
    chk(0, "locked_fc", 32'(b4.frame_count), 4);

    step(0, 1, 0, 0, 0);
    chk(0, "to_two", 32'(b4.wr_slot), 2);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 2'b11, 0);
    chk(0, "both_slot0", 32'(b4.rd_slot0), 2);
    chk(0, "both_slot1", 32'(b4.rd_slot1), 2);
    chk(0, "both_base1", 32'(b4.rd_base1), 32'h20000);
    chk(0, "both_grant", 32'(b4.rd_grant), 3);
    step(0, 0, 0, 0, 2'b01);
    chk(0, "rel0_held", 32'(b4.rd_held), 2);
    step(0, 1, 0, 0, 0);
    chk(0, "skip_newest", 32'(b4.wr_slot), 0);
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    chk(0, "skip_held1", 32'(b4.wr_slot), 1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 2'b10);
    step(0, 0, 0, 2'b01, 0);
    step(0, 1, 0, 0, 0);
    chk(0, "pre_two", 32'(b4.wr_slot), 0);
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    chk(0, "two_freed", 32'(b4.wr_slot), 2);
    chk(0, "two_base", 32'(b4.wr_base), 32'h20000);
    step(0, 0, 1, 0, 0);
    chk(0, "fc9", 32'(b4.frame_count), 9);

    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk(0, "abort_grant", 32'(b4.wr_grant), 1);
    chk(0, "abort_slot", 32'(b4.wr_slot), 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk(0, "idle_done_fc", 32'(b4.frame_count), 10);

    step(0, 0, 0, 0, 2'b01);
    step(0, 1, 0, 0, 0);
    chk(0, "race_wslot", 32'(b4.wr_slot), 1);
    step(0, 0, 1, 2'b10, 0);
    chk(0, "race_rd1", 32'(b4.rd_slot1), 0);
    chk(0, "race_newest", 32'(b4.newest_slot), 1);
    chk(0, "race_fc", 32'(b4.frame_count), 11);

    step(0, 1, 0, 0, 0);
    chk(0, "pre_rst_slot", 32'(b4.wr_slot), 2);
    rst_n = 1'b0;
    step(0, 1, 0, 0, 0);
    rst_n = 1'b1;
    chk(0, "rst_no_grant", 32'(b4.wr_grant), 0);
    chk(0, "rst_held", 32'(b4.rd_held), 0);
    chk(0, "rst_fc2", 32'(b4.frame_count), 0);

    step(1, 1, 0, 0, 0);
    chk(1, "s2_first", 32'(b2.wr_slot), 0);
    step(1, 0, 1, 0, 0);
    step(1, 0, 0, 2'b01, 0);
    step(1, 1, 0, 0, 0);
    chk(1, "s2_one", 32'(b2.wr_slot), 1);
    step(1, 1, 0, 0, 0);
    chk(1, "s2_regrant", 32'(b2.wr_grant), 1);
    chk(1, "s2_reslot", 32'(b2.wr_slot), 1);
    step(1, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    chk(1, "s2_drop", 32'(b2.wr_drop), 1);
    chk(1, "s2_nogrant", 32'(b2.wr_grant), 0);
    chk(1, "s2_dc1", 32'(b2.drop_count), 1);
    repeat (299) step(1, 1, 0, 0, 0);
    chk(1, "s2_dc_sat", 32'(b2.drop_count), 255);

    repeat (3000) begin
      for (int k = 0; k < 2; k++) begin
        ws[k] = ($urandom_range(0, 3) == 0);
        wd[k] = ($urandom_range(0, 2) == 0);
        ra[k] = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
        rr[k] = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
      end
      rst_n = ($urandom_range(0, 499) != 0);
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++) begin
      ws[k] = 0; wd[k] = 0; ra[k] = 0; rr[k] = 0;
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk(0, "no_drop_4slot", 32'(b4.drop_count), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
